goal_zone: RTL and testbench

Parametrised goal region for the Pacman playfield. It draws a rectangular goal on the VGA raster and tracks Pacman's position once per frame. When Pacman stays inside the rectangle for a set number of consecutive frames, the goal is captured and a one-cycle pulse goes to game logic. The fill is steady while armed, blinks while Pacman dwells inside, and is hidden once captured until game logic re-arms it.

---
 rtl/goal_zone.sv | 210 +++++++++++++++++++++
 tb/tb_goal_zone.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/goal_zone.sv
`default_nettype none
// ============================================================================
// Module   : goal_zone
// Purpose  : Rectangular goal region on the Pacman playfield. Draws the goal
//            on the VGA raster. Counts consecutive frames with Pacman inside
//            the rectangle and captures the goal once enough frames have
//            elapsed. The fill is steady while armed, blinks while Pacman
//            dwells, and is hidden once captured.
// Revision : 1.0 - initial release
// ============================================================================
module goal_zone #(
  parameter int XMIN         = 156,
  parameter int YMIN         = 8,
  parameter int XMAX         = 224,
  parameter int YMAX         = 48,
  parameter int OFFSETH      = 274,
  parameter int OFFSETV      = 58,
  parameter int DWELL_FRAMES = 30,
  parameter int BLINK_FRAMES = 8,
  parameter int CNT_W        = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       hCount,
  input  logic [9:0]       vCount,
  input  logic [9:0]       pacX,
  input  logic [9:0]       pacY,
  input  logic             enable,
  input  logic             rearm,
  output logic             goalFill,
  output logic             captured,
  output logic             capturePulse,
  output logic [CNT_W-1:0] dwellCount
);

  // Width of the blink frame counter: it counts 0 .. BLINK_FRAMES-1.
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Playfield bounds for the Pacman test, widened to 11 bits.
  localparam logic [10:0] c_X_LO = 11'(XMIN);
  localparam logic [10:0] c_X_HI = 11'(XMAX);
  localparam logic [10:0] c_Y_LO = 11'(YMIN);
  localparam logic [10:0] c_Y_HI = 11'(YMAX);

  // Screen bounds for the raster test; 11 bits so the offset sums fit.
  localparam logic [10:0] c_H_LO = 11'(XMIN + OFFSETH);
  localparam logic [10:0] c_H_HI = 11'(XMAX + OFFSETH);
  localparam logic [10:0] c_V_LO = 11'(YMIN + OFFSETV);
  localparam logic [10:0] c_V_HI = 11'(YMAX + OFFSETV);

  localparam logic [CNT_W-1:0] c_DWELL_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_DWELL_LAST = CNT_W'(DWELL_FRAMES - 1);
  localparam logic [CNT_W-1:0] c_DWELL_FULL = CNT_W'(DWELL_FRAMES);
  localparam logic [BLK_W-1:0] c_BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DWELL    = 2'd1,
    ST_CAPTURED = 2'd2
  } state_t;

  // Registered state
  state_t             r_state;
  logic [CNT_W-1:0]   r_dwellCount;
  logic [BLK_W-1:0]   r_blinkCnt;
  logic               r_blinkPhase;
  logic               r_prevZero;
  logic               r_goalFill;
  logic               r_captured;
  logic               r_capturePulse;

  // Combinational next-state values
  state_t             w_nextState;
  logic [CNT_W-1:0]   w_nextDwell;
  logic [BLK_W-1:0]   w_nextBlinkCnt;
  logic               w_nextBlinkPhase;

  logic               w_rasterZero;
  logic               w_frameTick;
  logic               w_inside;
  logic               w_inRect;
  logic               w_fillNext;
  logic               w_captureEntry;
  logic [10:0]        w_pacX11;
  logic [10:0]        w_pacY11;
  logic [10:0]        w_h11;
  logic [10:0]        w_v11;

  assign w_pacX11 = {1'b0, pacX};
  assign w_pacY11 = {1'b0, pacY};
  assign w_h11    = {1'b0, hCount};
  assign w_v11    = {1'b0, vCount};

  // The raster may sit at (0,0) for several clocks; only its first cycle
  // there counts as the frame tick.
  assign w_rasterZero = (hCount == 10'd0) && (vCount == 10'd0);
  assign w_frameTick  = w_rasterZero && !r_prevZero;

  assign w_inside = (w_pacX11 >= c_X_LO) && (w_pacX11 <= c_X_HI) &&
                    (w_pacY11 >= c_Y_LO) && (w_pacY11 <= c_Y_HI);

  assign w_inRect = (w_h11 >= c_H_LO) && (w_h11 <= c_H_HI) &&
                    (w_v11 >= c_V_LO) && (w_v11 <= c_V_HI);

  // Fill uses the current state; a state change shows up on the pixel one
  // cycle after the edge that made it.
  assign w_fillNext = w_inRect &&
                      ((r_state == ST_IDLE) ||
                       ((r_state == ST_DWELL) && r_blinkPhase));

  assign w_captureEntry = (r_state == ST_DWELL) && (w_nextState == ST_CAPTURED);

  // Remember the previous raster-zero condition; reset to 1 so a raster
  // already parked at (0,0) during reset does not fire a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prevZero <= 1'b1;
    end else begin
      r_prevZero <= w_rasterZero;
    end
  end

  // State, dwell counter and blink registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_dwellCount <= '0;
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b1;
    end else begin
      r_state      <= w_nextState;
      r_dwellCount <= w_nextDwell;
      r_blinkCnt   <= w_nextBlinkCnt;
      r_blinkPhase <= w_nextBlinkPhase;
    end
  end

  // Registered outputs: pixel fill, captured level and capture pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_goalFill     <= 1'b0;
      r_captured     <= 1'b0;
      r_capturePulse <= 1'b0;
    end else begin
      r_goalFill     <= w_fillNext;
      r_captured     <= (w_nextState == ST_CAPTURED);
      r_capturePulse <= w_captureEntry;
    end
  end

  // Next-state logic for dwell tracking, capture, re-arm and blinking.
  always_comb begin
    w_nextState      = r_state;
    w_nextDwell      = r_dwellCount;
    w_nextBlinkCnt   = r_blinkCnt;
    w_nextBlinkPhase = r_blinkPhase;
    case (r_state)
      ST_IDLE: begin
        if (w_frameTick && enable && w_inside) begin
          w_nextState      = ST_DWELL;
          w_nextDwell      = c_DWELL_ONE;
          w_nextBlinkCnt   = '0;
          w_nextBlinkPhase = 1'b1;
        end
      end
      ST_DWELL: begin
        // Losing enable aborts immediately, without waiting for a tick.
        if (!enable) begin
          w_nextState = ST_IDLE;
          w_nextDwell = '0;
        end else if (w_frameTick) begin
          if (!w_inside) begin
            w_nextState = ST_IDLE;
            w_nextDwell = '0;
          end else if (r_dwellCount == c_DWELL_LAST) begin
            w_nextState = ST_CAPTURED;
            w_nextDwell = c_DWELL_FULL;
          end else begin
            w_nextDwell = r_dwellCount + c_DWELL_ONE;
            if (r_blinkCnt == c_BLINK_LAST) begin
              w_nextBlinkCnt   = '0;
              w_nextBlinkPhase = ~r_blinkPhase;
            end else begin
              w_nextBlinkCnt = r_blinkCnt + BLK_W'(1);
            end
          end
        end
      end
      ST_CAPTURED: begin
        // Re-arm wins over a coincident tick: the block lands in IDLE and
        // only a later tick can start a new dwell.
        if (rearm) begin
          w_nextState = ST_IDLE;
          w_nextDwell = '0;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextDwell = '0;
      end
    endcase
  end

  assign goalFill     = r_goalFill;
  assign captured     = r_captured;
  assign capturePulse = r_capturePulse;
  assign dwellCount   = r_dwellCount;

endmodule
`default_nettype wire

// File: tb/tb_goal_zone.sv
`default_nettype none
// ============================================================================
// Module   : tb_goal_zone
// Purpose  : Self-checking bench for goal_zone. Two instances share stimulus:
//            A uses DWELL_FRAMES=4, B uses DWELL_FRAMES=10 for blink
//            observation. Expected values are queued with a target cycle and
//            a monitor compares them on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_goal_zone;

  localparam int CNT_W = 6;

  localparam int S_GF_A    = 0;
  localparam int S_CAP_A   = 1;
  localparam int S_PULSE_A = 2;
  localparam int S_DWELL_A = 3;
  localparam int S_GF_B    = 4;
  localparam int S_DWELL_B = 5;
  localparam int S_CAP_B   = 6;
  localparam int S_PULSE_B = 7;

  logic             clk;
  logic             reset;
  logic [9:0]       hCount;
  logic [9:0]       vCount;
  logic [9:0]       pacX;
  logic [9:0]       pacY;
  logic             enable;
  logic             rearm;

  logic             goalFill_a, captured_a, capturePulse_a;
  logic [CNT_W-1:0] dwellCount_a;
  logic             goalFill_b, captured_b, capturePulse_b;
  logic [CNT_W-1:0] dwellCount_b;

  goal_zone #(.DWELL_FRAMES(4), .BLINK_FRAMES(2), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .reset(reset), .hCount(hCount), .vCount(vCount),
    .pacX(pacX), .pacY(pacY), .enable(enable), .rearm(rearm),
    .goalFill(goalFill_a), .captured(captured_a),
    .capturePulse(capturePulse_a), .dwellCount(dwellCount_a)
  );

  goal_zone #(.DWELL_FRAMES(10), .BLINK_FRAMES(2), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .reset(reset), .hCount(hCount), .vCount(vCount),
    .pacX(pacX), .pacY(pacY), .enable(enable), .rearm(rearm),
    .goalFill(goalFill_b), .captured(captured_b),
    .capturePulse(capturePulse_b), .dwellCount(dwellCount_b)
  );

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  function automatic int actual(input int s);
    case (s)
      S_GF_A:    return int'(goalFill_a);
      S_CAP_A:   return int'(captured_a);
      S_PULSE_A: return int'(capturePulse_a);
      S_DWELL_A: return int'(dwellCount_a);
      S_GF_B:    return int'(goalFill_b);
      S_DWELL_B: return int'(dwellCount_b);
      S_CAP_B:   return int'(captured_b);
      S_PULSE_B: return int'(capturePulse_b);
      default:   return -1;
    endcase
  endfunction

  // Monitor: compare every queued expectation whose cycle has come.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc <= cyc) begin
          int a;
          a = actual(sb[i].sig);
          n_cmp = n_cmp + 1;
          if (a != sb[i].val) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     sb[i].name, a, sb[i].val, cyc);
          end
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // Queue an expectation d falling edges from now.
  task automatic expect_at(input int sig, input int val, input int d,
                           input string name);
    exp_t e;
    e.cyc  = cyc + d;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_begin();
    hCount = 10'd0;
    vCount = 10'd0;
  endtask

  task automatic tick_finish();
    step(4);
    hCount = 10'd100;
    vCount = 10'd100;
    step(1);
  endtask

  int fill_h  [5] = '{429, 430, 431, 498, 499};
  int fill_he [5] = '{0, 1, 1, 1, 0};
  int fill_v  [4] = '{65, 66, 106, 107};
  int fill_ve [4] = '{0, 1, 1, 0};
  int blink_e [6] = '{1, 1, 0, 0, 1, 1};

  initial begin
    reset  = 1'b1;
    hCount = 10'd100;
    vCount = 10'd100;
    pacX   = 10'd0;
    pacY   = 10'd0;
    enable = 1'b0;
    rearm  = 1'b0;

    // Reset values
    step(1);
    expect_at(S_GF_A,    0, 1, "rst_fill");
    expect_at(S_CAP_A,   0, 1, "rst_captured");
    expect_at(S_PULSE_A, 0, 1, "rst_pulse");
    expect_at(S_DWELL_A, 0, 1, "rst_dwell");
    expect_at(S_DWELL_B, 0, 1, "rst_dwell_b");
    step(2);
    reset = 1'b0;
    step(1);

    // Fill geometry in IDLE: horizontal edges at vCount 66
    vCount = 10'd66;
    for (int i = 0; i < 5; i++) begin
      hCount = 10'(fill_h[i]);
      expect_at(S_GF_A, fill_he[i], 1, "fill_h");
      step(1);
    end
    // Vertical edges at hCount 430
    hCount = 10'd430;
    for (int i = 0; i < 4; i++) begin
      vCount = 10'(fill_v[i]);
      expect_at(S_GF_A, fill_ve[i], 1, "fill_v");
      step(1);
    end
    hCount = 10'd100;
    vCount = 10'd100;
    step(1);

    // Capture after four inside ticks
    pacX   = 10'd190;
    pacY   = 10'd20;
    enable = 1'b1;
    step(1);
    for (int k = 1; k <= 4; k++) begin
      tick_begin();
      expect_at(S_DWELL_A, k, 1, "cap_dwell");
      expect_at(S_PULSE_A, (k == 4) ? 1 : 0, 1, "cap_pulse");
      expect_at(S_CAP_A,   (k == 4) ? 1 : 0, 1, "cap_captured");
      if (k == 4) begin
        expect_at(S_PULSE_A, 0, 2, "cap_pulse_width");
        expect_at(S_CAP_A,   1, 2, "cap_captured_hold");
      end
      tick_finish();
    end
    hCount = 10'd450;
    vCount = 10'd80;
    expect_at(S_GF_A,  0, 1, "cap_fill_hidden");
    expect_at(S_GF_A,  0, 2, "cap_fill_hidden2");
    expect_at(S_CAP_A, 1, 1, "cap_level");
    step(2);
    hCount = 10'd100;
    vCount = 10'd100;
    step(1);

    // Re-arm coincident with a tick while inside: no dwell starts
    tick_begin();
    rearm = 1'b1;
    expect_at(S_DWELL_A, 0, 1, "rearm_dwell");
    expect_at(S_CAP_A,   0, 1, "rearm_captured");
    expect_at(S_PULSE_A, 0, 1, "rearm_pulse");
    step(1);
    rearm = 1'b0;
    expect_at(S_DWELL_A, 0, 3, "rearm_no_dwell");
    tick_finish();
    hCount = 10'd450;
    vCount = 10'd80;
    expect_at(S_GF_A, 1, 1, "rearm_idle_fill");
    step(1);
    hCount = 10'd100;
    vCount = 10'd100;
    step(1);
    tick_begin();
    expect_at(S_DWELL_A, 1, 1, "rearm_next_dwell");
    tick_finish();

    // Dwell abort: Pacman leaves on the third tick
    tick_begin();
    expect_at(S_DWELL_A, 2, 1, "abort_dwell2");
    tick_finish();
    pacX = 10'd100;
    tick_begin();
    expect_at(S_DWELL_A, 0, 1, "abort_dwell0");
    expect_at(S_PULSE_A, 0, 1, "abort_pulse");
    expect_at(S_PULSE_A, 0, 2, "abort_pulse2");
    expect_at(S_CAP_A,   0, 1, "abort_captured");
    tick_finish();
    pacX = 10'd190;

    // Enable dropped mid-DWELL aborts on the next cycle
    tick_begin();
    expect_at(S_DWELL_A, 1, 1, "en_dwell1");
    tick_finish();
    enable = 1'b0;
    expect_at(S_DWELL_A, 0, 1, "en_drop");
    step(2);
    tick_begin();
    expect_at(S_DWELL_A, 0, 1, "en_low_idle");
    tick_finish();
    enable = 1'b1;
    step(1);

    // Reset asserted in DWELL with dwellCount=3
    for (int k = 1; k <= 3; k++) begin
      tick_begin();
      expect_at(S_DWELL_A, k, 1, "rst_mid_dwell");
      tick_finish();
    end
    reset  = 1'b1;
    hCount = 10'd450;
    vCount = 10'd80;
    expect_at(S_DWELL_A, 0, 1, "rst_mid_dwell0");
    expect_at(S_CAP_A,   0, 1, "rst_mid_captured");
    expect_at(S_PULSE_A, 0, 1, "rst_mid_pulse");
    expect_at(S_PULSE_A, 0, 2, "rst_mid_pulse2");
    expect_at(S_GF_A,    0, 1, "rst_mid_fill");
    expect_at(S_DWELL_B, 0, 1, "rst_mid_dwell_b");
    step(1);
    // Raster held at (0,0) across reset release gives no tick
    tick_begin();
    step(2);
    reset = 1'b0;
    expect_at(S_DWELL_A, 0, 1, "rst_held_zero1");
    expect_at(S_DWELL_A, 0, 2, "rst_held_zero2");
    expect_at(S_DWELL_A, 0, 3, "rst_held_zero3");
    tick_finish();
    tick_begin();
    expect_at(S_DWELL_A, 1, 1, "rst_first_tick");
    tick_finish();

    // Blink on instance B (DWELL_FRAMES=10)
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    for (int i = 0; i < 6; i++) begin
      tick_begin();
      expect_at(S_DWELL_B, i + 1, 1, "blink_dwell_b");
      expect_at(S_PULSE_B, 0, 1, "blink_pulse_b");
      expect_at(S_CAP_B,   0, 1, "blink_captured_b");
      tick_finish();
      hCount = 10'd450;
      vCount = 10'd80;
      expect_at(S_GF_B, blink_e[i], 1, "blink_fill_b");
      step(1);
      hCount = 10'd100;
      vCount = 10'd100;
      step(1);
    end

    step(3);
    n_cmp = n_cmp + 1;
    if (sb.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
